// File: rtl/register_bank_if.sv
// CPU-side bus bundle for register_bank: select/write controls in, register views out.
// The master modport drives the controls; the slave modport is taken by the bank.
interface register_bank_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 20,
   parameter int AW    = $clog2(DEPTH)
);
   localparam int NB = WIDTH / 8;

   logic                   clear;
   logic                   sel_we;
   logic [AW-1:0]          sel_d;
   logic                   auto_inc;
   logic                   wr_en;
   logic [NB-1:0]          wr_be;
   logic [WIDTH-1:0]       wr_d;
   logic                   commit;
   logic [AW-1:0]          sel_q;
   logic [WIDTH-1:0]       rd_data;
   logic [DEPTH*WIDTH-1:0] q_all;
   logic [DEPTH-1:0]       pending;

   modport master (
      output clear, sel_we, sel_d, auto_inc, wr_en, wr_be, wr_d, commit,
      input  sel_q, rd_data, q_all, pending
   );

   modport slave (
      input  clear, sel_we, sel_d, auto_inc, wr_en, wr_be, wr_d, commit,
      output sel_q, rd_data, q_all, pending
   );
endinterface

// File: rtl/register_bank.sv
// Byte-lane-writable VDC register bank with latched select, auto-increment and flat export.
// Latency: writes land one edge later; rd_data is combinational from sel_q. No backpressure.
// Optional frame-commit staging layer enabled by defining REGISTER_BANK_SHADOW_EN.
module register_bank #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 20,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic           clock,
   input  logic           reset_n,
   register_bank_if.slave bus
);
   localparam int NB = WIDTH / 8;
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   logic [AW-1:0]    sel_q;
   logic [DEPTH-1:0] sel_hit;
   logic             sel_ok;
   logic             wr_acc;
   logic             do_inc;
   logic [AW-1:0]    sel_nxt;
   logic [WIDTH-1:0] act [DEPTH];
   logic [WIDTH-1:0] rd_data;

   function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old,
                                              input logic [NB-1:0]    be,
                                              input logic [WIDTH-1:0] d);
      logic [WIDTH-1:0] r;
      r = old;
      for (int i = 0; i < NB; i++) begin
         if (be[i]) r[8*i +: 8] = d[8*i +: 8];
      end
      return r;
   endfunction

   // An out-of-range select matches no entry, which gates writes and zeroes rd_data.
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         sel_hit[k] = (sel_q == AW'(k));
      end
   end

   assign sel_ok = |sel_hit;
   assign wr_acc = bus.wr_en && sel_ok && (|bus.wr_be);
   assign do_inc = !bus.sel_we && bus.auto_inc && wr_acc && bus.wr_be[NB-1];

   always_comb begin
      sel_nxt = sel_q;
      if (bus.sel_we) begin
         sel_nxt = bus.sel_d;
      end else if (do_inc) begin
         sel_nxt = (sel_q == LAST) ? '0 : sel_q + AW'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sel_q <= '0;
      end else if (bus.clear) begin
         sel_q <= '0;
      end else begin
         sel_q <= sel_nxt;
      end
   end

`ifdef REGISTER_BANK_SHADOW_EN
   logic [WIDTH-1:0] stg [DEPTH];
   logic [DEPTH-1:0] pend;

   // Commit copies the pre-edge staging value; a same-cycle write re-arms pending.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            act[k] <= '0;
            stg[k] <= '0;
         end
         pend <= '0;
      end else if (bus.clear) begin
         for (int k = 0; k < DEPTH; k++) begin
            act[k] <= '0;
            stg[k] <= '0;
         end
         pend <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            if (bus.commit && pend[k]) act[k] <= stg[k];
            if (wr_acc && sel_hit[k]) begin
               stg[k]  <= merge(stg[k], bus.wr_be, bus.wr_d);
               pend[k] <= 1'b1;
            end else if (bus.commit) begin
               pend[k] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      rd_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (sel_hit[k]) rd_data = stg[k];
      end
   end

   assign bus.pending = pend;
`else
   logic unused_commit;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < DEPTH; k++) act[k] <= '0;
      end else if (bus.clear) begin
         for (int k = 0; k < DEPTH; k++) act[k] <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            if (wr_acc && sel_hit[k]) act[k] <= merge(act[k], bus.wr_be, bus.wr_d);
         end
      end
   end

   always_comb begin
      rd_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (sel_hit[k]) rd_data = act[k];
      end
   end

   assign unused_commit = bus.commit;
   assign bus.pending   = '0;
`endif

   for (genvar g = 0; g < DEPTH; g++) begin : g_export
      assign bus.q_all[g*WIDTH +: WIDTH] = act[g];
   end

   assign bus.sel_q   = sel_q;
   assign bus.rd_data = rd_data;
endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank: stimulus queues expectations, a negedge monitor checks them.
// Shadow-specific expectations follow REGISTER_BANK_SHADOW_EN.
module tb_register_bank;
   localparam int WIDTH = 16;
   localparam int DEPTH = 20;
   localparam int AW    = $clog2(DEPTH);

   localparam int K_SEL  = 0;
   localparam int K_RD   = 1;
   localparam int K_Q    = 2;
   localparam int K_PEND = 3;
   localparam int K_QOR  = 4;

   typedef struct {
      int          kind;
      int          idx;
      logic [31:0] exp;
      string       name;
   } chk_t;

   logic clock;
   logic reset_n;
   chk_t sb[$];
   int   n_cmp;
   int   n_err;

   register_bank_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   register_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input int kind, input int idx, input logic [31:0] exp, input string nm);
      chk_t c;
      c.kind = kind;
      c.idx  = idx;
      c.exp  = exp;
      c.name = nm;
      sb.push_back(c);
   endtask

   task automatic set_sel(input int a);
      bus.sel_we = 1'b1;
      bus.sel_d  = AW'(a);
      cyc();
      bus.sel_we = 1'b0;
   endtask

   task automatic wr(input logic [1:0] be, input logic [15:0] d);
      bus.wr_en = 1'b1;
      bus.wr_be = be;
      bus.wr_d  = d;
      cyc();
      bus.wr_en = 1'b0;
      bus.wr_be = '0;
   endtask

   task automatic sync();
      bus.commit = 1'b1;
      cyc();
      bus.commit = 1'b0;
   endtask

   // Monitor: samples on the falling edge, away from input changes and the active edge.
   initial begin
      chk_t        c;
      logic [31:0] act;
      forever begin
         @(negedge clock);
         while (sb.size() > 0) begin
            c = sb.pop_front();
            case (c.kind)
               K_SEL:   act = 32'(bus.sel_q);
               K_RD:    act = 32'(bus.rd_data);
               K_Q:     act = 32'(bus.q_all[c.idx*WIDTH +: WIDTH]);
               K_PEND:  act = 32'(bus.pending);
               default: act = 32'(|bus.q_all);
            endcase
            n_cmp++;
            if (act !== c.exp) begin
               n_err++;
               $display("FAIL %s: got %h want %h", c.name, act, c.exp);
            end
         end
      end
   end

   initial begin
      n_cmp        = 0;
      n_err        = 0;
      reset_n      = 1'b0;
      bus.clear    = 1'b0;
      bus.sel_we   = 1'b0;
      bus.sel_d    = '0;
      bus.auto_inc = 1'b0;
      bus.wr_en    = 1'b0;
      bus.wr_be    = '0;
      bus.wr_d     = '0;
      bus.commit   = 1'b0;
      repeat (3) cyc();
      reset_n = 1'b1;
      cyc();
      chk(K_SEL, 0, 0, "reset_sel");
      chk(K_RD, 0, 0, "reset_rd");
      chk(K_PEND, 0, 0, "reset_pend");
      chk(K_QOR, 0, 0, "reset_qall");

      // Byte lanes on register 5
      set_sel(5);
      wr(2'b11, 16'hABCD);
      wr(2'b01, 16'h0012);
      chk(K_SEL, 0, 5, "lane_sel");
      chk(K_RD, 0, 16'hAB12, "lane_rd");
`ifdef REGISTER_BANK_SHADOW_EN
      chk(K_Q, 5, 0, "lane_q5_staged");
      chk(K_PEND, 0, 32'h20, "lane_pend");
`else
      chk(K_Q, 5, 16'hAB12, "lane_q5_direct");
      chk(K_PEND, 0, 0, "lane_pend");
`endif
      sync();
      chk(K_Q, 5, 16'hAB12, "lane_q5");
      chk(K_Q, 4, 0, "lane_q4");
      chk(K_Q, 6, 0, "lane_q6");
      chk(K_PEND, 0, 0, "lane_pend_commit");

      // Auto-increment wrap and MSB-lane rule
      set_sel(DEPTH - 1);
      bus.auto_inc = 1'b1;
      wr(2'b11, 16'hBEEF);
      chk(K_SEL, 0, 0, "wrap_sel");
      wr(2'b01, 16'h0034);
      chk(K_SEL, 0, 0, "lsb_noinc_sel");
      chk(K_RD, 0, 16'h0034, "lsb_rd");
      wr(2'b00, 16'hFFFF);
      chk(K_SEL, 0, 0, "be0_sel");
      chk(K_RD, 0, 16'h0034, "be0_rd");
      wr(2'b10, 16'h5600);
      chk(K_SEL, 0, 1, "msb_inc_sel");
      sync();
      chk(K_Q, 19, 16'hBEEF, "wrap_q19");
      chk(K_Q, 0, 16'h5634, "msb_q0");

      // Select/write collision and out-of-range select
      set_sel(3);
      bus.sel_we = 1'b1;
      bus.sel_d  = AW'(7);
      wr(2'b11, 16'h3333);
      bus.sel_we = 1'b0;
      chk(K_SEL, 0, 7, "coll_sel");
      chk(K_RD, 0, 0, "coll_rd7");
      set_sel(3);
      chk(K_RD, 0, 16'h3333, "coll_rd3");
      set_sel(25);
      chk(K_SEL, 0, 25, "oor_sel");
      wr(2'b11, 16'hFFFF);
      chk(K_SEL, 0, 25, "oor_noinc");
      chk(K_RD, 0, 0, "oor_rd");
      sync();
      chk(K_Q, 3, 16'h3333, "coll_q3");
      chk(K_Q, 7, 0, "coll_q7");
      chk(K_Q, 0, 16'h5634, "oor_q0_hold");

      // Staging versus direct write behaviour
      bus.auto_inc = 1'b0;
`ifdef REGISTER_BANK_SHADOW_EN
      set_sel(2);
      wr(2'b11, 16'h1111);
      chk(K_Q, 2, 0, "shd_q2_hold");
      chk(K_PEND, 0, 32'h4, "shd_pend2");
      sync();
      chk(K_Q, 2, 16'h1111, "shd_q2_commit");
      chk(K_PEND, 0, 0, "shd_pend_clr");
      set_sel(8);
      wr(2'b11, 16'h8888);
      chk(K_PEND, 0, 32'h100, "shd_pend8");
      set_sel(2);
      bus.commit = 1'b1;
      wr(2'b11, 16'h2222);
      bus.commit = 1'b0;
      chk(K_Q, 2, 16'h1111, "shd_wc_q2");
      chk(K_Q, 8, 16'h8888, "shd_wc_q8");
      chk(K_PEND, 0, 32'h4, "shd_wc_pend");
      chk(K_RD, 0, 16'h2222, "shd_wc_rd");
      sync();
      chk(K_Q, 2, 16'h2222, "shd_q2_second");
      chk(K_PEND, 0, 0, "shd_pend_final");
      sync();
      chk(K_Q, 2, 16'h2222, "shd_idle_commit");
`else
      set_sel(2);
      wr(2'b11, 16'h1111);
      chk(K_Q, 2, 16'h1111, "dir_q2");
      chk(K_PEND, 0, 0, "dir_pend");
      bus.commit = 1'b1;
      wr(2'b11, 16'h2222);
      bus.commit = 1'b0;
      chk(K_Q, 2, 16'h2222, "dir_wc_q2");
      chk(K_PEND, 0, 0, "dir_wc_pend");
`endif

      // Clear beats a same-cycle write and commit
      set_sel(9);
      bus.auto_inc = 1'b1;
      wr(2'b11, 16'h9999);
      chk(K_SEL, 0, 10, "pre_clr_sel");
      bus.clear  = 1'b1;
      bus.commit = 1'b1;
      wr(2'b11, 16'hAAAA);
      bus.clear  = 1'b0;
      bus.commit = 1'b0;
      chk(K_SEL, 0, 0, "clr_sel");
      chk(K_QOR, 0, 0, "clr_qall");
      chk(K_PEND, 0, 0, "clr_pend");
      chk(K_RD, 0, 0, "clr_rd");

      // Asynchronous reset in the middle of a write burst
      wr(2'b11, 16'h1234);
      wr(2'b11, 16'h5678);
      sync();
      chk(K_SEL, 0, 2, "burst_sel");
      chk(K_QOR, 0, 1, "burst_qall");
      bus.wr_en = 1'b1;
      bus.wr_be = 2'b11;
      bus.wr_d  = 16'hCAFE;
      cyc();
      reset_n = 1'b0;
      chk(K_SEL, 0, 0, "arst_sel");
      chk(K_QOR, 0, 0, "arst_qall");
      chk(K_RD, 0, 0, "arst_rd");
      chk(K_PEND, 0, 0, "arst_pend");
      bus.wr_en = 1'b0;
      bus.wr_be = '0;
      repeat (2) cyc();
      reset_n = 1'b1;
      cyc();
      chk(K_SEL, 0, 0, "post_arst_sel");

      for (int i = 0; i < 10 && sb.size() > 0; i++) cyc();
      if (sb.size() > 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending checks want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
